// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester id and strobe width.
// The RMW_RD state is only reachable when DMEM_ARB_WSTRB_EN is defined.
package dmem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RMW_RD = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. On a tie the port not granted last wins; the history
// register only moves when the grant is actually accepted.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output req_id_t    o_grant,
    output logic       o_grant_valid
);

    req_id_t r_last_grant;

    always_comb begin
        o_grant_valid = |i_req;
        o_grant       = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = ~r_last_grant;
        end else if (i_req[1]) begin
            o_grant = 1'b1;
        end
    end

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_accept && o_grant_valid) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_memory (combinational read, synchronous write) between two requesters,
// one access at a time. Define DMEM_ARB_WSTRB_EN for read-modify-write byte-strobe support.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic                    m0_req_we,
    input  logic [31:0]             m0_req_addr,
    input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
    output logic                    m0_resp_valid,
    input  logic                    m0_resp_ready,
    output logic [DATA_WIDTH-1:0]   m0_resp_rdata,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic                    m1_req_we,
    input  logic [31:0]             m1_req_addr,
    input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
    output logic                    m1_resp_valid,
    input  logic                    m1_resp_ready,
    output logic [DATA_WIDTH-1:0]   m1_resp_rdata,

    output logic [31:0]             mem_a,
    output logic [DATA_WIDTH-1:0]   mem_wd,
    output logic                    mem_we,
    input  logic [DATA_WIDTH-1:0]   mem_rd
);

    localparam int LP_STRB_W = DATA_WIDTH / 8;

    state_t                  r_state;
    state_t                  w_next;
    req_id_t                 w_grant;
    req_id_t                 r_id;
    logic                    w_grant_valid;
    logic                    w_accept;
    logic                    w_resp_ready;

    logic                    w_sel_we;
    logic [29:0]             w_sel_word;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    logic                    r_we;
    logic [29:0]             r_word;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    w_unused_bits;

`ifdef DMEM_ARB_WSTRB_EN
    logic [LP_STRB_W-1:0]    w_sel_wstrb;
    logic [LP_STRB_W-1:0]    r_wstrb;
    logic [DATA_WIDTH-1:0]   w_merged;

    assign w_sel_wstrb   = w_grant ? m1_req_wstrb : m0_req_wstrb;
    assign w_unused_bits = ^{m0_req_addr[1:0], m1_req_addr[1:0]};

    always_comb begin
        w_merged = mem_rd;
        for (int b = 0; b < LP_STRB_W; b++) begin
            if (r_wstrb[b]) begin
                w_merged[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end
`else
    assign w_unused_bits = ^{m0_req_wstrb, m1_req_wstrb, m0_req_addr[1:0], m1_req_addr[1:0]};
`endif

    rr_arbiter2 u_rr_arbiter2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         ({m1_req_valid, m0_req_valid}),
        .i_accept      (w_accept),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // rst_n gates acceptance so ready stays low while reset is held in IDLE.
    assign w_accept     = rst_n && (r_state == ST_IDLE) && w_grant_valid;
    assign m0_req_ready = w_accept && (w_grant == 1'b0);
    assign m1_req_ready = w_accept && (w_grant == 1'b1);

    assign w_sel_we     = w_grant ? m1_req_we : m0_req_we;
    assign w_sel_word   = w_grant ? m1_req_addr[31:2] : m0_req_addr[31:2];
    assign w_sel_wdata  = w_grant ? m1_req_wdata : m0_req_wdata;
    assign w_resp_ready = r_id ? m1_resp_ready : m0_resp_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef DMEM_ARB_WSTRB_EN
                    w_next = (w_sel_we && !(&w_sel_wstrb)) ? ST_RMW_RD : ST_ACCESS;
`else
                    w_next = ST_ACCESS;
`endif
                end
            end
`ifdef DMEM_ARB_WSTRB_EN
            ST_RMW_RD: w_next = ST_ACCESS;
`endif
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP: begin
                if (w_resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A reset in the middle of an access simply drops it: no response is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
`ifdef DMEM_ARB_WSTRB_EN
            r_wstrb <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_id    <= w_grant;
                r_we    <= w_sel_we;
                r_word  <= w_sel_word;
                r_wdata <= w_sel_wdata;
`ifdef DMEM_ARB_WSTRB_EN
                r_wstrb <= w_sel_wstrb;
`endif
            end
`ifdef DMEM_ARB_WSTRB_EN
            if (r_state == ST_RMW_RD) begin
                r_wdata <= w_merged;
            end
`endif
            if (r_state == ST_ACCESS) begin
                r_rdata <= r_we ? '0 : mem_rd;
            end
        end
    end

    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (r_state == ST_ACCESS) begin
            mem_a  = {2'b00, r_word};
            mem_we = r_we;
            mem_wd = r_we ? r_wdata : '0;
        end
`ifdef DMEM_ARB_WSTRB_EN
        if (r_state == ST_RMW_RD) begin
            mem_a = {2'b00, r_word};
        end
`endif
    end

    assign m0_resp_valid = (r_state == ST_RESP) && (r_id == 1'b0);
    assign m1_resp_valid = (r_state == ST_RESP) && (r_id == 1'b1);
    assign m0_resp_rdata = (r_id == 1'b0) ? r_rdata : '0;
    assign m1_resp_rdata = (r_id == 1'b1) ? r_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model checked every cycle plus
// directed literal checks. Follows DMEM_ARB_WSTRB_EN the same way the design does.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic [3:0]  m0_req_wstrb;
    logic        m0_resp_valid, m0_resp_ready;
    logic [31:0] m0_resp_rdata;

    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic [3:0]  m1_req_wstrb;
    logic        m1_resp_valid, m1_resp_ready;
    logic [31:0] m1_resp_rdata;

    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    int          errCount = 0;
    int          checkCount = 0;
    int          weCount = 0;

    logic [31:0] memArr   [0:63];
    logic [31:0] modelMem [0:63];

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_req_we     (m0_req_we),
        .m0_req_addr   (m0_req_addr),
        .m0_req_wdata  (m0_req_wdata),
        .m0_req_wstrb  (m0_req_wstrb),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_ready (m0_resp_ready),
        .m0_resp_rdata (m0_resp_rdata),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_req_we     (m1_req_we),
        .m1_req_addr   (m1_req_addr),
        .m1_req_wdata  (m1_req_wdata),
        .m1_req_wstrb  (m1_req_wstrb),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_ready (m1_resp_ready),
        .m1_resp_rdata (m1_resp_rdata),
        .mem_a         (mem_a),
        .mem_wd        (mem_wd),
        .mem_we        (mem_we),
        .mem_rd        (mem_rd)
    );

    // Memory stand-in: combinational read, synchronous full-word write.
    assign mem_rd = memArr[mem_a[5:0]];
    always @(posedge clk) begin
        if (mem_we) memArr[mem_a[5:0]] <= mem_wd;
    end

    always @(negedge clk) begin
        if (mem_we) weCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction model: an accepted request is answered after a fixed number of cycles,
    // with memory contents tracked as a plain word array.
    logic        mBusy = 1'b0;
    logic        mLast = 1'b1;
    int          mK, mAccK;
    logic        mId, mWe;
    logic [31:0] mA, mWd, mRd;

    always @(negedge clk) begin
        logic        g;
        logic [31:0] oldW, newW, wd, addr;
        logic [3:0]  strb;
        logic        we;
        if (!rst_n) begin
            checkOutput("rst_m0_req_ready", 32'(m0_req_ready), 32'd0);
            checkOutput("rst_m1_req_ready", 32'(m1_req_ready), 32'd0);
            checkOutput("rst_m0_resp_valid", 32'(m0_resp_valid), 32'd0);
            checkOutput("rst_m1_resp_valid", 32'(m1_resp_valid), 32'd0);
            checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
            checkOutput("rst_mem_a", mem_a, 32'd0);
            checkOutput("rst_mem_wd", mem_wd, 32'd0);
            checkOutput("rst_m0_rdata", m0_resp_rdata, 32'd0);
            checkOutput("rst_m1_rdata", m1_resp_rdata, 32'd0);
            mBusy = 1'b0;
            mLast = 1'b1;
        end else if (!mBusy) begin
            g = (m0_req_valid && m1_req_valid) ? ~mLast : m1_req_valid;
            checkOutput("idle_m0_req_ready", 32'(m0_req_ready), 32'(m0_req_valid && g == 1'b0));
            checkOutput("idle_m1_req_ready", 32'(m1_req_ready), 32'(m1_req_valid && g == 1'b1));
            checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
            checkOutput("idle_mem_a", mem_a, 32'd0);
            checkOutput("idle_mem_wd", mem_wd, 32'd0);
            checkOutput("idle_m0_resp_valid", 32'(m0_resp_valid), 32'd0);
            checkOutput("idle_m1_resp_valid", 32'(m1_resp_valid), 32'd0);
            if (m0_req_valid || m1_req_valid) begin
                we   = g ? m1_req_we : m0_req_we;
                addr = g ? m1_req_addr : m0_req_addr;
                wd   = g ? m1_req_wdata : m0_req_wdata;
                strb = g ? m1_req_wstrb : m0_req_wstrb;
                oldW = modelMem[addr[7:2]];
                mAccK = 1;
`ifdef DMEM_ARB_WSTRB_EN
                newW = oldW;
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) newW[8*b +: 8] = wd[8*b +: 8];
                end
                if (we && strb != 4'hF) mAccK = 2;
`else
                newW = wd;
`endif
                mBusy = 1'b1;
                mK    = 0;
                mLast = g;
                mId   = g;
                mWe   = we;
                mA    = {2'b00, addr[31:2]};
                mWd   = newW;
                mRd   = we ? 32'd0 : oldW;
                if (we) modelMem[addr[7:2]] = newW;
            end
        end else begin
            mK++;
            checkOutput("busy_m0_req_ready", 32'(m0_req_ready), 32'd0);
            checkOutput("busy_m1_req_ready", 32'(m1_req_ready), 32'd0);
            if (mK <= mAccK) begin
                checkOutput("access_mem_a", mem_a, mA);
                checkOutput("access_m0_resp_valid", 32'(m0_resp_valid), 32'd0);
                checkOutput("access_m1_resp_valid", 32'(m1_resp_valid), 32'd0);
                if (mK == mAccK) begin
                    checkOutput("access_mem_we", 32'(mem_we), 32'(mWe));
                    if (mWe) checkOutput("access_mem_wd", mem_wd, mWd);
                end else begin
                    checkOutput("rmw_mem_we", 32'(mem_we), 32'd0);
                    checkOutput("rmw_mem_wd", mem_wd, 32'd0);
                end
            end else begin
                checkOutput("resp_mem_a", mem_a, 32'd0);
                checkOutput("resp_mem_we", 32'(mem_we), 32'd0);
                checkOutput("resp_mem_wd", mem_wd, 32'd0);
                checkOutput("resp_m0_valid", 32'(m0_resp_valid), 32'(mId == 1'b0));
                checkOutput("resp_m1_valid", 32'(m1_resp_valid), 32'(mId == 1'b1));
                checkOutput("resp_rdata", mId ? m1_resp_rdata : m0_resp_rdata, mRd);
                if (mId ? m1_resp_ready : m0_resp_ready) mBusy = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        if (port == 0) begin
            m0_req_we = we; m0_req_addr = addr; m0_req_wdata = wdata; m0_req_wstrb = wstrb;
            m0_req_valid = 1'b1;
        end else begin
            m1_req_we = we; m1_req_addr = addr; m1_req_wdata = wdata; m1_req_wstrb = wstrb;
            m1_req_valid = 1'b1;
        end
    endtask

    task automatic waitAccept(input int port, output int waited);
        logic found = 1'b0;
        waited = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            waited++;
            if (port == 0 ? m0_req_ready : m1_req_ready) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("accept_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        if (port == 0) m0_req_valid = 1'b0; else m1_req_valid = 1'b0;
    endtask

    task automatic waitResp(input int port, output logic [31:0] rd, output int waited);
        logic found = 1'b0;
        waited = 0;
        rd = 32'hxxxx_xxxx;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            waited++;
            if (port == 0 ? m0_resp_valid : m1_resp_valid) begin
                found = 1'b1;
                rd = (port == 0) ? m0_resp_rdata : m1_resp_rdata;
                break;
            end
        end
        checkOutput("resp_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        int          order[$];
        int          expOrder[4];
        int          c0, c1;
        logic [31:0] expStrb, expZero;

        for (int i = 0; i < 64; i++) begin
            memArr[i] <= 32'd0;
            modelMem[i] = 32'd0;
        end
        memArr[4]   <= 32'hDEADBEEF;
        modelMem[4] = 32'hDEADBEEF;

        rst_n = 1'b0;
        m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_wstrb = '0;
        m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_wstrb = '0;
        m0_resp_ready = 1'b1;
        m1_resp_ready = 1'b1;

        $display("[TB] reset with both requests valid");
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'hF);
        applyStimulus(1, 1'b0, 32'h20, 32'd0, 4'hF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        waitAccept(0, w);
        checkOutput("reset_first_grant_m0", 32'(w), 32'd1);
        waitResp(0, rd, w);
        checkOutput("reset_m0_rdata", rd, 32'hDEADBEEF);
        waitAccept(1, w);
        waitResp(1, rd, w);
        checkOutput("reset_m1_rdata", rd, 32'd0);

        $display("[TB] single read");
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'hF);
        waitAccept(0, w);
        checkOutput("single_mem_a", mem_a, 32'd4);
        waitResp(0, rd, w);
        checkOutput("single_rdata", rd, 32'hDEADBEEF);
        checkOutput("single_latency", 32'(w), 32'd2);

        $display("[TB] write then read");
        weCount = 0;
        applyStimulus(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        waitAccept(1, w);
        waitResp(1, rd, w);
        checkOutput("write_resp_rdata", rd, 32'd0);
        checkOutput("write_we_pulses", 32'(weCount), 32'd1);
        applyStimulus(1, 1'b0, 32'h20, 32'd0, 4'hF);
        waitAccept(1, w);
        waitResp(1, rd, w);
        checkOutput("readback_rdata", rd, 32'h12345678);

        $display("[TB] tie arbitration");
        expOrder = '{0, 1, 0, 1};
        c0 = 0; c1 = 0;
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'hF);
        applyStimulus(1, 1'b0, 32'h20, 32'd0, 4'hF);
        for (int i = 0; i < 80 && (c0 + c1) < 4; i++) begin
            @(negedge clk);
            if (m0_req_ready) begin
                order.push_back(0); c0++;
                @(posedge clk); #1;
                if (c0 == 2) m0_req_valid = 1'b0;
            end else if (m1_req_ready) begin
                order.push_back(1); c1++;
                @(posedge clk); #1;
                if (c1 == 2) m1_req_valid = 1'b0;
            end
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("tie_order_%0d", i),
                        (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(expOrder[i]));
        end
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] response backpressure");
        m0_resp_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'hF);
        waitAccept(0, w);
        applyStimulus(1, 1'b0, 32'h20, 32'd0, 4'hF);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_m0_resp_valid", 32'(m0_resp_valid), 32'd1);
            checkOutput("bp_m0_rdata", m0_resp_rdata, 32'hDEADBEEF);
            checkOutput("bp_m1_req_ready", 32'(m1_req_ready), 32'd0);
        end
        @(posedge clk); #1;
        m0_resp_ready = 1'b1;
        waitAccept(1, w);
        waitResp(1, rd, w);
        checkOutput("bp_m1_rdata", rd, 32'h12345678);

        $display("[TB] strobe writes");
`ifdef DMEM_ARB_WSTRB_EN
        expStrb = 32'hAA22CC44;
        expZero = 32'hAA22CC44;
`else
        expStrb = 32'h11223344;
        expZero = 32'h55667788;
`endif
        applyStimulus(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'hF);
        waitAccept(0, w);
        waitResp(0, rd, w);
        applyStimulus(0, 1'b1, 32'h30, 32'h11223344, 4'b0101);
        waitAccept(0, w);
        waitResp(0, rd, w);
`ifdef DMEM_ARB_WSTRB_EN
        checkOutput("strobe_latency", 32'(w), 32'd3);
`else
        checkOutput("strobe_latency", 32'(w), 32'd2);
`endif
        applyStimulus(0, 1'b0, 32'h30, 32'd0, 4'hF);
        waitAccept(0, w);
        waitResp(0, rd, w);
        checkOutput("strobe_readback", rd, expStrb);
        applyStimulus(0, 1'b1, 32'h30, 32'h55667788, 4'b0000);
        waitAccept(0, w);
        waitResp(0, rd, w);
        applyStimulus(0, 1'b0, 32'h30, 32'd0, 4'hF);
        waitAccept(0, w);
        waitResp(0, rd, w);
        checkOutput("zero_strobe_readback", rd, expZero);

        $display("[TB] reset during an access");
        applyStimulus(1, 1'b0, 32'h20, 32'd0, 4'hF);
        waitAccept(1, w);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("dropped_m1_resp_valid", 32'(m1_resp_valid), 32'd0);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares one `data_memory` instance between two requesters:
  - Port 0: core load/store unit.
  - Port 1: DMA/debug loader.
- Arbitrates round-robin, services one access at a time and returns a registered response per port.
- The memory read is combinational and the write is synchronous; the arbiter owns `mem_we` and sequences both.

## Interface
- `DATA_WIDTH`, 32, data word width; strobe width is `DATA_WIDTH/8`.
- `clk` in 1, single clock; all state on rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `mN_req_valid` in 1, request valid, N ∈ {0,1}.
- `mN_req_ready` out 1, request accepted this cycle.
- `mN_req_we` in 1, 1 = write, 0 = read.
- `mN_req_addr` in 32, byte address; bits [1:0] ignored.
- `mN_req_wdata` in DATA_WIDTH, write data.
- `mN_req_wstrb` in DATA_WIDTH/8, byte strobes.
- `mN_resp_valid` out 1, response valid.
- `mN_resp_ready` in 1, response consumed.
- `mN_resp_rdata` out DATA_WIDTH, read data; 0 for writes.
- `mem_a` out 32, word address to memory: `{2'b00, addr[31:2]}`.
- `mem_wd` out DATA_WIDTH, memory write data.
- `mem_we` out 1, memory write enable.
- `mem_rd` in DATA_WIDTH, combinational memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP; RMW_RD is added only under the configuration macro.
- **IDLE**
  - If any `req_valid`, grant one requester.
  - Assert that port's `req_ready` combinationally, same cycle.
  - Latch we/addr/wdata/wstrb and the grant id.
  - Go to ACCESS, or to RMW_RD for a partial-strobe write when the macro is defined.
- **Arbitration**
  - Single valid request wins.
  - If both are valid, the port not granted last wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - `last_grant` updates only on an accepted grant.
- **ACCESS**
  - Drive `mem_a` from the latched address.
  - Write: `mem_we`=1 and `mem_wd`=latched/merged data; memory writes at the end of the cycle.
  - Read: capture `mem_rd` into the response register at the end of the cycle.
  - Go to RESP.
- **RESP**
  - Granted port's `resp_valid`=1; the other port's `resp_valid`=0.
  - `rdata` is held stable until `resp_ready`.
  - On `resp_ready`, go to IDLE.
- `req_ready` is 0 outside IDLE, so no pipelining: one outstanding access total.
- `mem_we` is 1 only in ACCESS with latched we=1. Outside ACCESS, `mem_a`=0 and `mem_wd`=0.
- Reset values: state IDLE, all `req_ready`/`resp_valid`/`mem_we`=0, `resp_rdata`=0, `mem_a`=0, `mem_wd`=0.
- Reset asserted mid-access: the access is dropped and no response is issued. A write is lost unless its ACCESS cycle had already completed.

## Timing
- Accept at edge N, ACCESS in cycle N+1, `resp_valid` from cycle N+2.
- Best-case repeat rate is one access per 3 cycles (4 with RMW).
- Back-to-back: `resp_ready` at cycle N+2 → IDLE at N+3; the next grant is accepted in cycle N+3.
- A requester may hold `req_valid` while the other is served. Its request must stay stable until `req_ready`.

## Configuration
- `DMEM_ARB_WSTRB_EN` defined:
  - Write with `wstrb` != all-ones goes IDLE→RMW_RD→ACCESS.
  - RMW_RD drives `mem_a` and captures `mem_rd`.
  - ACCESS writes the merge: strobed bytes from wdata, others from old data.
  - `wstrb`=0 still takes a cycle and writes back old data unchanged.
- Macro undefined:
  - `wstrb` is ignored and every write is a full word.
  - RMW_RD state does not exist.

## Structure
- Package `dmem_arb_pkg`:
  - State enum (IDLE, RMW_RD, ACCESS, RESP).
  - Requester-id typedef.
  - `STRB_W` constant.
- Sub-module `rr_arbiter2`: 2-way round-robin grant with `last_grant` register, advancing on accept.
- Top holds the FSM, request latch, response register and RMW merge.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 with both requests valid.
  - Check: all `req_ready`/`resp_valid`/`mem_we`=0; after release, port 0 is granted first.
- Single read:
  - Stimulus: m0 reads addr 0x10 with memory word 4 = 0xDEADBEEF.
  - Check: `mem_a`=4 in ACCESS; `m0_resp_rdata`=0xDEADBEEF at N+2.
- Write then read:
  - Stimulus: m1 writes 0x12345678 to 0x20, then reads 0x20.
  - Check: `mem_we` pulses exactly one cycle; the read returns 0x12345678.
- Tie arbitration:
  - Stimulus: both valid continuously for 4 accesses.
  - Check: grant order is 0,1,0,1.
- Backpressure:
  - Stimulus: hold `m0_resp_ready`=0 for 5 cycles.
  - Check: `resp_valid`/`rdata` are stable and `m1_req_ready` stays 0 until the response is consumed.
- Strobe write (macro on):
  - Stimulus: word 0xAABBCCDD; write 0x11223344 with `wstrb`=4'b0101.
  - Check: readback 0xAA22CC44; with the macro off, readback 0x11223344.
